// File: rtl/comb_core_pkg.sv
// Shared types and helpers for the combinational-core pattern driver.
// Helpers work on 32-bit containers; callers pass the real width and cast the result.
package comb_core_pkg;

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StDone} state_e;

    localparam logic [17:0] LfsrPolyDef = 18'h20400;
    localparam logic [15:0] MisrPolyDef = 16'h1021;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] pat, input logic [31:0] poly,
                                              input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'h1 << w) - 32'h1);
        return ((pat << 1) | {31'b0, ^(pat & poly & mask)}) & mask;
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic b,
                                              input logic [31:0] poly, input int unsigned w);
        logic [31:0] mask;
        logic        fb;
        mask = (w >= 32) ? '1 : ((32'h1 << w) - 32'h1);
        fb   = sig[w-1] ^ b;
        return ((sig << 1) ^ (fb ? poly : 32'h0)) & mask;
    endfunction

endpackage

// File: rtl/comb_core_pattern_driver_lfsr.sv
// Registered pattern LFSR: loads a seed (zero replaced by 1 to avoid lockup) or steps.
module pattern_lfsr
    import comb_core_pkg::*;
#(
    parameter int unsigned       NumIn = 18,
    parameter logic [NumIn-1:0] Poly  = LfsrPolyDef
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [NumIn-1:0] seed_i,
    input  logic             step_i,
    output logic [NumIn-1:0] pat_o
);

    logic [NumIn-1:0] pat_d, pat_q;

    always_comb begin
        pat_d = pat_q;
        if (load_i) begin
            pat_d = (seed_i == '0) ? NumIn'(1) : seed_i;
        end else if (step_i) begin
            pat_d = NumIn'(lfsr_next(32'(pat_q), 32'(Poly), NumIn));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat_o = pat_q;

endmodule

// File: rtl/comb_core_pattern_driver.sv
// Drives an 18-input netlist from an LFSR, holds each pattern SettleCyc cycles, then
// compacts the sampled response into a MISR signature and a saturating ones-count.
module comb_core_pattern_driver
    import comb_core_pkg::*;
#(
    parameter int unsigned       NumIn     = 18,
    parameter logic [NumIn-1:0] LfsrPoly  = LfsrPolyDef,
    parameter int unsigned       SigW      = 16,
    parameter logic [SigW-1:0]  MisrPoly  = MisrPolyDef,
    parameter int unsigned       CntW      = 16,
    parameter int unsigned       SettleCyc = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [NumIn-1:0] seed_i,
    input  logic [CntW-1:0]  num_patterns_i,
    output logic [NumIn-1:0] pat_out_o,
    input  logic             resp_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CntW-1:0]  ones_count_o,
    output logic [SigW-1:0]  signature_o
);

    localparam int unsigned SetW = (SettleCyc > 1) ? $clog2(SettleCyc) : 1;
    localparam logic [SetW-1:0] SetReload = SetW'(SettleCyc - 1);

    state_e          state_d, state_q;
    logic [SetW-1:0] cnt_d, cnt_q;
    logic [CntW-1:0] idx_d, idx_q;
    logic [CntW-1:0] npat_d, npat_q;
    logic [SigW-1:0] sig_d, sig_q;
    logic [CntW-1:0] ones_d, ones_q;
    logic            busy_d, busy_q;
    logic            lfsr_load, lfsr_step;
    logic [CntW-1:0] idx_inc;

    assign idx_inc = idx_q + CntW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        npat_d    = npat_q;
        sig_d     = sig_q;
        ones_d    = ones_q;
        busy_d    = busy_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                // abort has priority over a simultaneous start
                if (start_i && !abort_i) begin
                    sig_d  = '0;
                    ones_d = '0;
                    idx_d  = '0;
                    if (num_patterns_i != '0) begin
                        lfsr_load = 1'b1;
                        npat_d    = num_patterns_i;
                        busy_d    = 1'b1;
                        cnt_d     = SetReload;
                        state_d   = StSettle;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSettle: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - SetW'(1);
                end
            end
            StCapture: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    sig_d = SigW'(misr_next(32'(sig_q), resp_in_i, 32'(MisrPoly), SigW));
                    if (resp_in_i && (ones_q != '1)) begin
                        ones_d = ones_q + CntW'(1);
                    end
                    idx_d = idx_inc;
                    if (idx_inc == npat_q) begin
                        busy_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        lfsr_step = 1'b1;
                        cnt_d     = SetReload;
                        state_d   = StSettle;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            npat_q  <= '0;
            sig_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            npat_q  <= npat_d;
            sig_q   <= sig_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
        end
    end

    pattern_lfsr #(
        .NumIn (NumIn),
        .Poly  (LfsrPoly)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (lfsr_load),
        .seed_i (seed_i),
        .step_i (lfsr_step),
        .pat_o  (pat_out_o)
    );

    assign busy_o       = busy_q;
    assign done_o       = (state_q == StDone);
    assign ones_count_o = ones_q;
    assign signature_o  = sig_q;

endmodule

// File: tb/tb_comb_core_pattern_driver.sv
// Directed bench for comb_core_pattern_driver (SettleCyc = 2); cycle 1 is the cycle right
// after the start-accept edge, sampled on the falling edge.
module tb_comb_core_pattern_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [17:0] seed;
    logic [15:0] num;
    logic [17:0] pat_out;
    logic        resp_in;
    logic        busy, done;
    logic [15:0] ones, sig;
    logic        resp_mode, resp_const;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    comb_core_pattern_driver #(
        .SettleCyc (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .seed_i         (seed),
        .num_patterns_i (num),
        .pat_out_o      (pat_out),
        .resp_in_i      (resp_in),
        .busy_o         (busy),
        .done_o         (done),
        .ones_count_o   (ones),
        .signature_o    (sig)
    );

    // Stand-in for the generated 18-input netlist.
    function automatic logic netlist_f(input logic [17:0] p);
        return ((p[0] ^ p[5] ^ p[11]) ^ (p[17] & p[9])) ^ ((p[3] | ~p[12]) & p[7]);
    endfunction

    always_comb resp_in = resp_mode ? netlist_f(pat_out) : resp_const;

    task automatic do_start(input logic [17:0] s, input logic [15:0] n);
        @(negedge clk);
        seed  = s;
        num   = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_cycles(input int limit, input int pat_cyc, output int done_cyc,
                              output int busy_cnt, output int busy_last,
                              output logic [17:0] pat_at);
        done_cyc  = 0;
        busy_cnt  = 0;
        busy_last = 0;
        pat_at    = '0;
        for (int k = 1; k <= limit && done_cyc == 0; k++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                busy_last = k;
            end
            if (k == pat_cyc) pat_at = pat_out;
            if (done) done_cyc = k;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        asserts++; if (pat_out !== 18'h0) begin fails++; $display("FAIL reset_pat: got %h want 0", pat_out); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        asserts++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        asserts++; if (ones !== 16'h0) begin fails++; $display("FAIL reset_ones: got %h want 0", ones); end
        asserts++; if (sig !== 16'h0) begin fails++; $display("FAIL reset_sig: got %h want 0", sig); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int dc, bc, bl;
        logic [17:0] p;
        resp_const = 1'b1;
        do_start(18'h00001, 16'd1);
        run_cycles(20, 1, dc, bc, bl, p);
        asserts++; if (p !== 18'h00001) begin fails++; $display("FAIL single_pat: got %h want 00001", p); end
        asserts++; if (dc !== 4) begin fails++; $display("FAIL single_done_cyc: got %0d want 4", dc); end
        asserts++; if (bc !== 3 || bl !== 3) begin fails++; $display("FAIL single_busy: got cnt %0d last %0d want 3/3", bc, bl); end
        asserts++; if (sig !== 16'h1021) begin fails++; $display("FAIL single_sig: got %h want 1021", sig); end
        asserts++; if (ones !== 16'd1) begin fails++; $display("FAIL single_ones: got %0d want 1", ones); end
        @(negedge clk);
        asserts++; if (done !== 1'b0 || sig !== 16'h1021) begin fails++; $display("FAIL single_hold: got done %b sig %h want 0/1021", done, sig); end
    endtask

    task automatic test_two;
        int dc, bc, bl;
        logic [17:0] p;
        resp_const = 1'b1;
        do_start(18'h00001, 16'd2);
        run_cycles(20, 4, dc, bc, bl, p);
        asserts++; if (p !== 18'h00002) begin fails++; $display("FAIL two_pat2: got %h want 00002", p); end
        asserts++; if (dc !== 7) begin fails++; $display("FAIL two_done_cyc: got %0d want 7", dc); end
        asserts++; if (sig !== 16'h3063) begin fails++; $display("FAIL two_sig: got %h want 3063", sig); end
        asserts++; if (ones !== 16'd2) begin fails++; $display("FAIL two_ones: got %0d want 2", ones); end
    endtask

    task automatic test_zero_n;
        int dc, bc, bl;
        logic [17:0] p;
        do_start(18'h00005, 16'd0);
        run_cycles(5, 1, dc, bc, bl, p);
        asserts++; if (dc !== 1) begin fails++; $display("FAIL zero_n_done_cyc: got %0d want 1", dc); end
        asserts++; if (bc !== 0) begin fails++; $display("FAIL zero_n_busy: got %0d busy cycles want 0", bc); end
        asserts++; if (sig !== 16'h0 || ones !== 16'h0) begin fails++; $display("FAIL zero_n_clear: got sig %h ones %h want 0/0", sig, ones); end
    endtask

    task automatic test_zero_seed;
        int dc, bc, bl;
        logic [17:0] p;
        resp_const = 1'b0;
        do_start(18'h00000, 16'd3);
        run_cycles(20, 1, dc, bc, bl, p);
        asserts++; if (p !== 18'h00001) begin fails++; $display("FAIL zseed_pat: got %h want 00001", p); end
        asserts++; if (dc !== 10) begin fails++; $display("FAIL zseed_done_cyc: got %0d want 10", dc); end
        asserts++; if (sig !== 16'h0 || ones !== 16'h0) begin fails++; $display("FAIL zseed_result: got sig %h ones %h want 0/0", sig, ones); end
    endtask

    task automatic test_abort;
        int seen_done;
        resp_const = 1'b1;
        do_start(18'h00001, 16'd5);
        @(negedge clk);                 // cycle 1
        @(negedge clk);                 // cycle 2: stray start must be ignored
        start = 1'b1; num = 16'd1; seed = 18'h00abc;
        @(negedge clk);                 // cycle 3 (capture)
        start = 1'b0;
        @(negedge clk);                 // cycle 4: second settle
        asserts++; if (busy !== 1'b1 || pat_out !== 18'h00002) begin fails++; $display("FAIL abort_pre: got busy %b pat %h want 1/00002", busy, pat_out); end
        abort = 1'b1;
        @(negedge clk);                 // cycle 5
        abort = 1'b0;
        asserts++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_idle: got busy %b done %b want 0/0", busy, done); end
        asserts++; if (ones !== 16'd1 || sig !== 16'h1021 || pat_out !== 18'h00002) begin
            fails++; $display("FAIL abort_partial: got ones %0d sig %h pat %h want 1/1021/00002", ones, sig, pat_out);
        end
        seen_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        asserts++; if (seen_done !== 0) begin fails++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen_done); end
        // abort and start together in idle: run must not start
        start = 1'b1; abort = 1'b1; num = 16'd3; seed = 18'h00040;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        asserts++; if (busy !== 1'b0 || done !== 1'b0 || pat_out !== 18'h00002) begin
            fails++; $display("FAIL abort_start: got busy %b done %b pat %h want 0/0/00002", busy, done, pat_out);
        end
    endtask

    task automatic test_reset_midrun;
        resp_const = 1'b1;
        do_start(18'h00001, 16'd5);
        repeat (4) @(negedge clk);      // cycle 4: one capture done
        rst_n = 1'b0;
        #1;
        asserts++; if (pat_out !== 18'h0 || busy !== 1'b0 || sig !== 16'h0 || ones !== 16'h0) begin
            fails++; $display("FAIL midrun_reset: got pat %h busy %b sig %h ones %h want all 0", pat_out, busy, sig, ones);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_long;
        logic [17:0] mp, prev;
        logic [15:0] msig, mones;
        logic        r, fb;
        int dc, ndist, reps;
        bit seen [logic [17:0]];
        mp = 18'h3FFFF; msig = '0; mones = '0;
        for (int i = 0; i < 1000; i++) begin
            r    = netlist_f(mp);
            fb   = msig[15] ^ r;
            msig = {msig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            mones = mones + {15'b0, r};
            mp   = {mp[16:0], mp[17] ^ mp[10]};
        end
        resp_mode = 1'b1;
        do_start(18'h3FFFF, 16'd1000);
        dc = 0; ndist = 0; reps = 0; prev = 18'h0;
        for (int k = 1; k <= 3100 && dc == 0; k++) begin
            @(negedge clk);
            if (busy && pat_out !== prev) begin
                if (seen.exists(pat_out)) reps++;
                seen[pat_out] = 1'b1;
                ndist++;
                prev = pat_out;
            end
            if (done) dc = k;
        end
        resp_mode = 1'b0;
        asserts++; if (dc !== 3001) begin fails++; $display("FAIL long_done_cyc: got %0d want 3001", dc); end
        asserts++; if (sig !== msig) begin fails++; $display("FAIL long_sig: got %h want %h", sig, msig); end
        asserts++; if (ones !== mones) begin fails++; $display("FAIL long_ones: got %0d want %0d", ones, mones); end
        asserts++; if (ndist !== 1000 || reps !== 0) begin fails++; $display("FAIL long_seq: got %0d patterns %0d repeats want 1000/0", ndist, reps); end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; seed = '0; num = '0;
        resp_mode = 1'b0; resp_const = 1'b0;
        test_reset();
        test_single();
        test_two();
        test_zero_n();
        test_zero_seed();
        test_abort();
        test_reset_midrun();
        test_long();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
